kv_lut_writer: RTL and testbench

Builds and maintains the packed key/data lookup table consumed by the key-select mux family. The table is written through a valid/ready write port and can be cleared by a sequential sweep. The block drives a lut bus laid out exactly as the mux expects: entry n occupies bits [PAIR_LEN*(n+1)-1 : PAIR_LEN*n], key in the upper KEY_LEN bits and data in the lower DATA_LEN bits. Together with the mux it forms a runtime-programmable key-select path.

---
 rtl/kv_lut_pkg.sv | 19 +
 rtl/kv_lut_free_find.sv | 23 ++
 rtl/kv_lut_writer.sv | 173 +++++++++++++++++
 tb/tb_kv_lut_writer.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kv_lut_pkg.sv
// Shared types and helpers for the key/data lookup-table writer.
// Holds the FSM state encoding and slice/width helpers used by the top and the bench.
package kv_lut_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } kv_state_e;

    // Low bit of entry n inside the packed lut bus.
    function automatic int pair_lo(input int n, input int key_len, input int data_len);
        return n * (key_len + data_len);
    endfunction

    function automatic int cnt_width(input int nr_key);
        return $clog2(nr_key + 1);
    endfunction

endpackage

// File: rtl/kv_lut_free_find.sv
// Lowest-index-zero priority encoder: finds the first unoccupied table slot.
module kv_lut_free_find #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  mask,
    output logic [IW-1:0] idx,
    output logic          found
);

    // Scan downward so the lowest free index is the last one written.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (!mask[i]) begin
                idx   = IW'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/kv_lut_writer.sv
// Maintains the packed key/data table for the key-select mux via a valid/ready write port.
// Build option KV_LUT_WRITER_EVICT_EN: a miss while full replaces a round-robin victim.
module kv_lut_writer
    import kv_lut_pkg::*;
#(
    parameter int NR_KEY   = 4,
    parameter int KEY_LEN  = 2,
    parameter int DATA_LEN = 2
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   wr_valid,
    output logic                                   wr_ready,
    input  logic [KEY_LEN-1:0]                     wr_key,
    input  logic [DATA_LEN-1:0]                    wr_data,
    input  logic                                   clr,
    output logic                                   clear_busy,
    output logic [NR_KEY*(KEY_LEN+DATA_LEN)-1:0]   lut,
    output logic [NR_KEY-1:0]                      valid_mask,
    output logic [cnt_width(NR_KEY)-1:0]           count,
    output logic                                   full
);

    localparam int PAIR_LEN = KEY_LEN + DATA_LEN;
    localparam int IW       = $clog2(NR_KEY);
    localparam int CW       = cnt_width(NR_KEY);

    kv_state_e             state_q, state_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [KEY_LEN-1:0]    keys_q [NR_KEY];
    logic [KEY_LEN-1:0]    keys_d [NR_KEY];
    logic [DATA_LEN-1:0]   data_q [NR_KEY];
    logic [DATA_LEN-1:0]   data_d [NR_KEY];
    logic [NR_KEY-1:0]     valid_q, valid_d;
    logic [CW-1:0]         count_q, count_d;

`ifdef KV_LUT_WRITER_EVICT_EN
    logic [IW-1:0]         victim_q, victim_d;
    localparam bit         EVICT_OK = 1'b1;
`else
    localparam bit         EVICT_OK = 1'b0;
`endif

    logic                  hit;
    logic [IW-1:0]         hit_idx;
    logic [IW-1:0]         free_idx;
    logic                  free_found;
    logic                  accept;
    logic [IW-1:0]         tgt;

    kv_lut_free_find #(.N(NR_KEY), .IW(IW)) u_free_find (
        .mask  (valid_q),
        .idx   (free_idx),
        .found (free_found)
    );

    // Keys are unique, so at most one valid entry can match.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = 0; i < NR_KEY; i++) begin
            if (valid_q[i] && (keys_q[i] == wr_key)) begin
                hit     = 1'b1;
                hit_idx = IW'(i);
            end
        end
    end

    assign wr_ready = rst_n && (state_q == ST_IDLE) && !clr && (hit || free_found || EVICT_OK);
    assign accept   = wr_valid && wr_ready;

    always_comb begin
        tgt = free_idx;
        if (hit) begin
            tgt = hit_idx;
        end
`ifdef KV_LUT_WRITER_EVICT_EN
        else if (!free_found) begin
            tgt = victim_q;
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        keys_d  = keys_q;
        data_d  = data_q;
        valid_d = valid_q;
        count_d = count_q;
`ifdef KV_LUT_WRITER_EVICT_EN
        victim_d = victim_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (clr) begin
                    state_d = ST_CLEAR;
                    idx_d   = '0;
                end else if (accept) begin
                    keys_d[tgt]  = wr_key;
                    data_d[tgt]  = wr_data;
                    valid_d[tgt] = 1'b1;
                    if (!hit && free_found) begin
                        count_d = count_q + CW'(1);
                    end
`ifdef KV_LUT_WRITER_EVICT_EN
                    if (!hit && !free_found) begin
                        victim_d = (victim_q == IW'(NR_KEY - 1)) ? '0 : victim_q + IW'(1);
                    end
`endif
                end
            end
            ST_CLEAR: begin
                keys_d[idx_q]  = '0;
                data_d[idx_q]  = '0;
                valid_d[idx_q] = 1'b0;
                count_d        = count_q - CW'(valid_q[idx_q]);
                idx_d          = idx_q + IW'(1);
                if (idx_q == IW'(NR_KEY - 1)) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
`ifdef KV_LUT_WRITER_EVICT_EN
                    victim_d = '0;
`endif
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            valid_q <= '0;
            count_q <= '0;
            for (int i = 0; i < NR_KEY; i++) begin
                keys_q[i] <= '0;
                data_q[i] <= '0;
            end
`ifdef KV_LUT_WRITER_EVICT_EN
            victim_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            count_q <= count_d;
            for (int i = 0; i < NR_KEY; i++) begin
                keys_q[i] <= keys_d[i];
                data_q[i] <= data_d[i];
            end
`ifdef KV_LUT_WRITER_EVICT_EN
            victim_q <= victim_d;
`endif
        end
    end

    always_comb begin
        lut = '0;
        for (int i = 0; i < NR_KEY; i++) begin
            lut[pair_lo(i, KEY_LEN, DATA_LEN) +: PAIR_LEN] = {keys_q[i], data_q[i]};
        end
    end

    assign valid_mask = valid_q;
    assign count      = count_q;
    assign full       = (count_q == CW'(NR_KEY));
    assign clear_busy = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_kv_lut_writer.sv
// Directed and scoreboard-checked bench for kv_lut_writer.
// A second instance with 3-bit keys reaches the miss-while-full case that 2-bit keys cannot.
module tb_kv_lut_writer;

`ifdef KV_LUT_WRITER_EVICT_EN
    localparam bit EV = 1'b1;
`else
    localparam bit EV = 1'b0;
`endif

    logic        clk;
    logic        rst_n;

    logic        wr_valid, wr_ready, clr, clear_busy, full;
    logic [1:0]  wr_key, wr_data;
    logic [15:0] lut;
    logic [3:0]  valid_mask;
    logic [2:0]  count;

    logic        wr_valid_3, wr_ready_3, clr_3, clear_busy_3, full_3;
    logic [2:0]  wr_key_3;
    logic [1:0]  wr_data_3;
    logic [19:0] lut_3;
    logic [3:0]  valid_mask_3;
    logic [2:0]  count_3;

    int n_vec = 0;
    int n_err = 0;

    logic [19:0] exp_q[$];
    logic [2:0]  m_key [4];
    logic [1:0]  m_dat [4];
    bit          m_val [4];

    kv_lut_writer #(.NR_KEY(4), .KEY_LEN(2), .DATA_LEN(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_key(wr_key), .wr_data(wr_data), .clr(clr), .clear_busy(clear_busy),
        .lut(lut), .valid_mask(valid_mask), .count(count), .full(full)
    );

    kv_lut_writer #(.NR_KEY(4), .KEY_LEN(3), .DATA_LEN(2)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid_3), .wr_ready(wr_ready_3),
        .wr_key(wr_key_3), .wr_data(wr_data_3), .clr(clr_3), .clear_busy(clear_busy_3),
        .lut(lut_3), .valid_mask(valid_mask_3), .count(count_3), .full(full_3)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic wr(input logic [1:0] k, input logic [1:0] d, output bit acc);
        wr_valid = 1'b1;
        wr_key   = k;
        wr_data  = d;
        #1;
        acc = wr_ready;
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
    endtask

    task automatic wr3(input logic [2:0] k, input logic [1:0] d, output bit acc);
        wr_valid_3 = 1'b1;
        wr_key_3   = k;
        wr_data_3  = d;
        #1;
        acc = wr_ready_3;
        @(posedge clk);
        #1;
        wr_valid_3 = 1'b0;
    endtask

    function automatic logic [1:0] mux3(input logic [19:0] l, input logic [3:0] m,
                                        input logic [2:0] k);
        logic [1:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            if (m[i] && (l[i*5+2 +: 3] == k)) r = r | l[i*5 +: 2];
        end
        return r;
    endfunction

    function automatic logic [19:0] model_lut();
        logic [19:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) r[i*5 +: 5] = {m_key[i], m_dat[i]};
        return r;
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        wr_valid = 0; wr_key = 0; wr_data = 0; clr = 0;
        wr_valid_3 = 0; wr_key_3 = 0; wr_data_3 = 0; clr_3 = 0;
        #12;
        n_vec++;
        if ({wr_ready, clear_busy, full, count, valid_mask, lut} !== 26'd0) begin
            n_err++;
            $display("FAIL reset: ready=%b busy=%b full=%b count=%0d mask=%b lut=%h, required all 0",
                     wr_ready, clear_busy, full, count, valid_mask, lut);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_vec++;
        if (wr_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_ready: wr_ready=%b, required 1", wr_ready);
        end
    endtask

    task automatic test_basic_write();
        bit a0, a1;
        wr(2'd2, 2'd3, a0);
        wr(2'd1, 2'd1, a1);
        n_vec++;
        if (!a0 || !a1 || lut !== 16'h005B || valid_mask !== 4'b0011 || count !== 3'd2 || full !== 1'b0) begin
            n_err++;
            $display("FAIL basic_write: acc=%b%b lut=%h mask=%b count=%0d full=%b, required 11 005b 0011 2 0",
                     a0, a1, lut, valid_mask, count, full);
        end
    endtask

    task automatic test_hit_update();
        bit a;
        wr(2'd2, 2'd0, a);
        n_vec++;
        if (!a || lut !== 16'h0058 || valid_mask !== 4'b0011 || count !== 3'd2) begin
            n_err++;
            $display("FAIL hit_update: acc=%b lut=%h mask=%b count=%0d, required 1 0058 0011 2",
                     a, lut, valid_mask, count);
        end
    endtask

    task automatic test_fill();
        bit a0, a1, a2;
        wr(2'd0, 2'd2, a0);
        n_vec++;
        if (!a0 || lut !== 16'h0258 || count !== 3'd3 || full !== 1'b0) begin
            n_err++;
            $display("FAIL fill_3: acc=%b lut=%h count=%0d full=%b, required 1 0258 3 0", a0, lut, count, full);
        end
        wr(2'd3, 2'd1, a1);
        n_vec++;
        if (!a1 || lut !== 16'hD258 || count !== 3'd4 || full !== 1'b1 || valid_mask !== 4'b1111) begin
            n_err++;
            $display("FAIL fill_full: acc=%b lut=%h count=%0d full=%b mask=%b, required 1 d258 4 1 1111",
                     a1, lut, count, full, valid_mask);
        end
        wr(2'd2, 2'd1, a2);
        n_vec++;
        if (!a2 || lut !== 16'hD259 || count !== 3'd4) begin
            n_err++;
            $display("FAIL full_hit: acc=%b lut=%h count=%0d, required 1 d259 4", a2, lut, count);
        end
    endtask

    task automatic test_full_miss();
        bit a;
        bit acc[4];
        wr3(3'd1, 2'd1, acc[0]);
        wr3(3'd2, 2'd2, acc[1]);
        wr3(3'd3, 2'd3, acc[2]);
        wr3(3'd4, 2'd0, acc[3]);
        n_vec++;
        if (!(acc[0] && acc[1] && acc[2] && acc[3]) || lut_3 !== 20'h83D45 || full_3 !== 1'b1) begin
            n_err++;
            $display("FAIL miss_fill: lut=%h full=%b, required 83d45 1", lut_3, full_3);
        end
        wr3(3'd5, 2'd3, a);
        n_vec++;
        if (a !== EV || lut_3 !== (EV ? 20'h83D57 : 20'h83D45) || count_3 !== 3'd4) begin
            n_err++;
            $display("FAIL miss_full_1: acc=%b lut=%h count=%0d, required %b %h 4",
                     a, lut_3, count_3, EV, EV ? 20'h83D57 : 20'h83D45);
        end
        wr3(3'd6, 2'd0, a);
        n_vec++;
        if (a !== EV || lut_3 !== (EV ? 20'h83F17 : 20'h83D45) || count_3 !== 3'd4) begin
            n_err++;
            $display("FAIL miss_full_2: acc=%b lut=%h count=%0d, required %b %h 4",
                     a, lut_3, count_3, EV, EV ? 20'h83F17 : 20'h83D45);
        end
    endtask

    task automatic test_clear_with_write();
        logic [2:0] exp_cnt;
        clr      = 1'b1;
        wr_valid = 1'b1;
        wr_key   = 2'd1;
        wr_data  = 2'd2;
        #1;
        n_vec++;
        if (wr_ready !== 1'b0) begin
            n_err++;
            $display("FAIL clr_wins_ready: wr_ready=%b, required 0", wr_ready);
        end
        @(posedge clk);
        #1;
        clr = 1'b0;
        n_vec++;
        if (lut !== 16'hD259 || wr_ready !== 1'b0) begin
            n_err++;
            $display("FAIL clr_write_dropped: lut=%h ready=%b, required d259 0", lut, wr_ready);
        end
        wr_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            exp_cnt = 3'(4 - c);
            n_vec++;
            if (clear_busy !== 1'b1 || count !== exp_cnt) begin
                n_err++;
                $display("FAIL sweep_cycle%0d: busy=%b count=%0d, required 1 %0d", c, clear_busy, count, exp_cnt);
            end
            @(posedge clk);
            #1;
        end
        n_vec++;
        if (clear_busy !== 1'b0 || lut !== 16'h0 || count !== 3'd0 || valid_mask !== 4'b0 || wr_ready !== 1'b1) begin
            n_err++;
            $display("FAIL after_clear: busy=%b lut=%h count=%0d mask=%b ready=%b, required 0 0000 0 0000 1",
                     clear_busy, lut, count, valid_mask, wr_ready);
        end
    endtask

    task automatic test_reset_mid_sweep();
        bit a;
        wr(2'd1, 2'd2, a);
        wr(2'd2, 2'd1, a);
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        @(posedge clk);
        #1;
        n_vec++;
        if (clear_busy !== 1'b1 || count !== 3'd1) begin
            n_err++;
            $display("FAIL mid_sweep_pre: busy=%b count=%0d, required 1 1", clear_busy, count);
        end
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (clear_busy !== 1'b0 || lut !== 16'h0 || count !== 3'd0 || valid_mask !== 4'b0 || wr_ready !== 1'b0) begin
            n_err++;
            $display("FAIL mid_sweep_reset: busy=%b lut=%h count=%0d mask=%b ready=%b, required 0 0000 0 0000 0",
                     clear_busy, lut, count, valid_mask, wr_ready);
        end
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_vec++;
        if (clear_busy !== 1'b0 || wr_ready !== 1'b1 || count !== 3'd0) begin
            n_err++;
            $display("FAIL post_reset_idle: busy=%b ready=%b count=%0d, required 0 1 0", clear_busy, wr_ready, count);
        end
    endtask

    task automatic test_random();
        logic [2:0]  k;
        logic [1:0]  d;
        bit          v, c, hit, found, exp_rdy, m_busy;
        int          hit_i, free_i, m_idx, m_vict, m_cnt, tgt;
        logic [19:0] exp_lut;
        logic [1:0]  got;

        for (int i = 0; i < 4; i++) begin
            m_key[i] = '0; m_dat[i] = '0; m_val[i] = 0;
        end
        m_busy = 0; m_idx = 0; m_vict = 0;
        // Start from an empty table on the 3-bit-key instance.
        clr_3 = 1'b1;
        @(posedge clk);
        #1;
        clr_3 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        n_vec++;
        if (lut_3 !== 20'h0 || count_3 !== 3'd0 || clear_busy_3 !== 1'b0) begin
            n_err++;
            $display("FAIL rand_init: lut=%h count=%0d busy=%b, required 0 0 0", lut_3, count_3, clear_busy_3);
        end

        for (int cyc = 0; cyc < 1000; cyc++) begin
            k = 3'($urandom_range(0, 7));
            d = 2'($urandom_range(0, 3));
            v = ($urandom_range(0, 1) == 1);
            c = ($urandom_range(0, 49) == 0);
            wr_key_3 = k; wr_data_3 = d; wr_valid_3 = v; clr_3 = c;
            #1;
            hit = 0; hit_i = 0; found = 0; free_i = 0;
            for (int i = 0; i < 4; i++) begin
                if (m_val[i] && m_key[i] == k) begin hit = 1; hit_i = i; end
            end
            for (int i = 3; i >= 0; i--) begin
                if (!m_val[i]) begin found = 1; free_i = i; end
            end
            exp_rdy = !m_busy && !c && (hit || found || EV);
            n_vec++;
            if (wr_ready_3 !== exp_rdy) begin
                n_err++;
                $display("FAIL rand_ready cyc%0d: wr_ready=%b, required %b", cyc, wr_ready_3, exp_rdy);
            end
            if (m_busy) begin
                m_key[m_idx] = '0; m_dat[m_idx] = '0; m_val[m_idx] = 0;
                if (m_idx == 3) begin m_busy = 0; m_vict = 0; end
                m_idx = (m_idx + 1) % 4;
            end else if (c) begin
                m_busy = 1; m_idx = 0;
            end else if (v && exp_rdy) begin
                tgt = hit ? hit_i : (found ? free_i : m_vict);
                if (!hit && !found) m_vict = (m_vict + 1) % 4;
                m_key[tgt] = k; m_dat[tgt] = d; m_val[tgt] = 1;
            end
            exp_q.push_back(model_lut());
            @(posedge clk);
            #1;
            exp_lut = exp_q.pop_front();
            m_cnt = 0;
            for (int i = 0; i < 4; i++) m_cnt += int'(m_val[i]);
            n_vec++;
            if (lut_3 !== exp_lut || count_3 !== 3'(m_cnt) || clear_busy_3 !== m_busy) begin
                n_err++;
                $display("FAIL rand_state cyc%0d: lut=%h count=%0d busy=%b, required %h %0d %b",
                         cyc, lut_3, count_3, clear_busy_3, exp_lut, m_cnt, m_busy);
            end
            if ((cyc % 50) == 49) begin
                for (int i = 0; i < 4; i++) begin
                    if (m_val[i]) begin
                        got = mux3(lut_3, valid_mask_3, m_key[i]);
                        n_vec++;
                        if (got !== m_dat[i]) begin
                            n_err++;
                            $display("FAIL rand_mux key%0d: data=%0d, required %0d", m_key[i], got, m_dat[i]);
                        end
                    end
                end
            end
        end
        wr_valid_3 = 1'b0;
        clr_3      = 1'b0;
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        test_reset();
        test_basic_write();
        test_hit_update();
        test_fill();
        test_full_miss();
        test_clear_with_write();
        test_reset_mid_sweep();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
